// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe SS AXI-S shims: per-segment tuser layout,
// TX merge arbiter states and source identifiers.
package ofs_fim_pcie_ss_shims_pkg;

  typedef struct packed {
    logic       dm_mode;
    logic       sop;
    logic       eop;
    logic [4:0] rsvd;
  } t_tuser_seg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_CPL = 2'd1,
    LOCK_REQ = 2'd2
  } t_tx_merge_state;

  typedef enum logic {
    SRC_CPL = 1'b0,
    SRC_REQ = 1'b1
  } t_tx_src;

endpackage

// File: rtl/pcie_ss_axis_skid2.sv
// Two-entry registered skid buffer; the output is always taken from the head
// register so downstream sees no combinational path from the input side.
module pcie_ss_axis_skid2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      unique case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_head <= i_data;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_push) begin
            r_tail <= i_data;
            r_cnt  <= 2'd2;
          end else if (w_pop) begin
            r_cnt <= 2'd0;
          end
        end
        default: begin
          // Full: no push is possible, a pop promotes the tail.
          if (w_pop) begin
            r_head <= r_tail;
            r_cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pcie_ss_axis_tx_dual_merge.sv
// Merges the completion and request AXI-S streams into one PCIe SS TX stream,
// arbitrating only at packet boundaries and registering through a skid buffer.
module pcie_ss_axis_tx_dual_merge
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned NUM_OF_SEG    = DATA_WIDTH/256,
  parameter int unsigned USER_W        = NUM_OF_SEG*$bits(ofs_fim_pcie_ss_shims_pkg::t_tuser_seg),
  parameter bit          CPL_PRIORITY  = 1'b1,
  parameter int unsigned MAX_CPL_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_cpl_tvalid,
  output logic                    in_cpl_tready,
  input  logic [DATA_WIDTH-1:0]   in_cpl_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_cpl_tkeep,
  input  logic                    in_cpl_tlast,
  input  logic [USER_W-1:0]       in_cpl_tuser,
  input  logic                    in_req_tvalid,
  output logic                    in_req_tready,
  input  logic [DATA_WIDTH-1:0]   in_req_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_req_tkeep,
  input  logic                    in_req_tlast,
  input  logic [USER_W-1:0]       in_req_tuser,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic [DATA_WIDTH-1:0]   out_tdata,
  output logic [DATA_WIDTH/8-1:0] out_tkeep,
  output logic                    out_tlast,
  output logic [USER_W-1:0]       out_tuser,
  output logic                    out_src
);

  localparam int unsigned KEEP_W    = DATA_WIDTH/8;
  localparam int unsigned PLD_W     = DATA_WIDTH + KEEP_W + 1 + USER_W + 1;
  localparam logic [7:0]  BURST_MAX = 8'(MAX_CPL_BURST);

  t_tx_merge_state r_state;
  t_tx_src         r_rr;
  logic [7:0]      r_burst;
  logic            r_run;

  logic             w_sel_cpl;
  logic             w_sel_req;
  logic             w_skid_rdy;
  logic             w_cpl_fire;
  logic             w_req_fire;
  logic [PLD_W-1:0] w_in_pld;
  logic [PLD_W-1:0] w_out_pld;

  always_comb begin
    w_sel_cpl = 1'b0;
    w_sel_req = 1'b0;
    unique case (r_state)
      LOCK_CPL: w_sel_cpl = 1'b1;
      LOCK_REQ: w_sel_req = 1'b1;
      default: begin
        if (in_req_tvalid &&
            (!in_cpl_tvalid ||
             (CPL_PRIORITY ? (r_burst == BURST_MAX) : (r_rr == SRC_REQ))))
          w_sel_req = 1'b1;
        else if (in_cpl_tvalid)
          w_sel_cpl = 1'b1;
      end
    endcase
  end

  // r_run holds both treadys low while reset is asserted and for its release cycle.
  assign in_cpl_tready = r_run & w_skid_rdy & w_sel_cpl;
  assign in_req_tready = r_run & w_skid_rdy & w_sel_req;
  assign w_cpl_fire    = in_cpl_tvalid & in_cpl_tready;
  assign w_req_fire    = in_req_tvalid & in_req_tready;

  assign w_in_pld = w_sel_req
    ? {in_req_tdata, in_req_tkeep, in_req_tlast, in_req_tuser, 1'b1}
    : {in_cpl_tdata, in_cpl_tkeep, in_cpl_tlast, in_cpl_tuser, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr    <= SRC_CPL;
      r_burst <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_cpl_fire) begin
            r_rr <= SRC_REQ;
            if (in_req_tvalid && (r_burst != BURST_MAX))
              r_burst <= r_burst + 8'd1;
            if (!in_cpl_tlast)
              r_state <= LOCK_CPL;
          end else if (w_req_fire) begin
            r_rr    <= SRC_CPL;
            r_burst <= '0;
            if (!in_req_tlast)
              r_state <= LOCK_REQ;
          end
        end
        LOCK_CPL: begin
          if (w_cpl_fire && in_cpl_tlast)
            r_state <= IDLE;
        end
        LOCK_REQ: begin
          if (w_req_fire && in_req_tlast)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  pcie_ss_axis_skid2 #(
    .W (PLD_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_cpl_fire | w_req_fire),
    .o_ready (w_skid_rdy),
    .i_data  (w_in_pld),
    .o_valid (out_tvalid),
    .i_ready (out_tready),
    .o_data  (w_out_pld)
  );

  assign {out_tdata, out_tkeep, out_tlast, out_tuser, out_src} = w_out_pld;

endmodule

// File: tb/tb_pcie_ss_axis_tx_dual_merge.sv
// Scoreboard bench for the TX dual-stream merge: a priority instance for most
// scenarios plus a round-robin instance driven with fixed-length packets.
module tb_pcie_ss_axis_tx_dual_merge;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW/8;
  localparam int unsigned UW = (DW/256)*$bits(ofs_fim_pcie_ss_shims_pkg::t_tuser_seg);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  typedef struct packed {
    logic        src;
    logic [31:0] cyc;
    beat_t       b;
  } obs_t;

  logic clk, rst_n;
  logic in_cpl_tvalid, in_cpl_tready, in_cpl_tlast;
  logic [DW-1:0] in_cpl_tdata;
  logic [KW-1:0] in_cpl_tkeep;
  logic [UW-1:0] in_cpl_tuser;
  logic in_req_tvalid, in_req_tready, in_req_tlast;
  logic [DW-1:0] in_req_tdata;
  logic [KW-1:0] in_req_tkeep;
  logic [UW-1:0] in_req_tuser;
  logic out_tvalid, out_tready, out_tlast, out_src;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [UW-1:0] out_tuser;

  logic rr_cpl_tvalid, rr_cpl_tready, rr_cpl_tlast;
  logic rr_req_tvalid, rr_req_tready, rr_req_tlast;
  logic [DW-1:0] rr_cpl_tdata, rr_req_tdata, rr_out_tdata;
  logic [KW-1:0] rr_keep, rr_out_tkeep;
  logic [UW-1:0] rr_user, rr_out_tuser;
  logic rr_out_tvalid, rr_out_tready, rr_out_tlast, rr_out_src;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cpl_first_acc = -1;
  int unsigned pkt_seq = 0;
  int unsigned vld_pct = 100;
  int unsigned rdy_pct = 100;
  int unsigned rr_cpl_n = 0;
  int unsigned rr_req_n = 0;
  bit rr_en = 0;
  bit cpl_fired = 0;
  bit req_fired = 0;
  bit req_rdy_seen = 0;

  beat_t cpl_txq[$], req_txq[$], exp_cpl[$], exp_req[$];
  obs_t  obs[$];
  logic [32:0] rr_obs[$];

  pcie_ss_axis_tx_dual_merge #(
    .DATA_WIDTH    (DW),
    .CPL_PRIORITY  (1'b1),
    .MAX_CPL_BURST (4)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_cpl_tvalid (in_cpl_tvalid), .in_cpl_tready (in_cpl_tready),
    .in_cpl_tdata (in_cpl_tdata), .in_cpl_tkeep (in_cpl_tkeep),
    .in_cpl_tlast (in_cpl_tlast), .in_cpl_tuser (in_cpl_tuser),
    .in_req_tvalid (in_req_tvalid), .in_req_tready (in_req_tready),
    .in_req_tdata (in_req_tdata), .in_req_tkeep (in_req_tkeep),
    .in_req_tlast (in_req_tlast), .in_req_tuser (in_req_tuser),
    .out_tvalid (out_tvalid), .out_tready (out_tready),
    .out_tdata (out_tdata), .out_tkeep (out_tkeep),
    .out_tlast (out_tlast), .out_tuser (out_tuser), .out_src (out_src)
  );

  pcie_ss_axis_tx_dual_merge #(
    .DATA_WIDTH    (DW),
    .CPL_PRIORITY  (1'b0),
    .MAX_CPL_BURST (4)
  ) dut_rr (
    .clk (clk), .rst_n (rst_n),
    .in_cpl_tvalid (rr_cpl_tvalid), .in_cpl_tready (rr_cpl_tready),
    .in_cpl_tdata (rr_cpl_tdata), .in_cpl_tkeep (rr_keep),
    .in_cpl_tlast (rr_cpl_tlast), .in_cpl_tuser (rr_user),
    .in_req_tvalid (rr_req_tvalid), .in_req_tready (rr_req_tready),
    .in_req_tdata (rr_req_tdata), .in_req_tkeep (rr_keep),
    .in_req_tlast (rr_req_tlast), .in_req_tuser (rr_user),
    .out_tvalid (rr_out_tvalid), .out_tready (rr_out_tready),
    .out_tdata (rr_out_tdata), .out_tkeep (rr_out_tkeep),
    .out_tlast (rr_out_tlast), .out_tuser (rr_out_tuser), .out_src (rr_out_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers: all input and out_tready updates happen 1 time unit after posedge.
  initial begin
    in_cpl_tvalid = 1'b0; in_cpl_tdata = '0; in_cpl_tkeep = '0; in_cpl_tlast = 1'b0; in_cpl_tuser = '0;
    in_req_tvalid = 1'b0; in_req_tdata = '0; in_req_tkeep = '0; in_req_tlast = 1'b0; in_req_tuser = '0;
    out_tready = 1'b1; rr_out_tready = 1'b1; rr_keep = '1; rr_user = '0;
    rr_cpl_tvalid = 1'b0; rr_cpl_tdata = '0; rr_cpl_tlast = 1'b0;
    rr_req_tvalid = 1'b0; rr_req_tdata = '0; rr_req_tlast = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      out_tready = ($urandom_range(99) < rdy_pct);
      if (!rst_n) begin
        in_cpl_tvalid = 1'b0;
        in_req_tvalid = 1'b0;
      end else begin
        if (!(in_cpl_tvalid && !cpl_fired)) begin
          if (cpl_txq.size() > 0 && $urandom_range(99) < vld_pct) begin
            in_cpl_tvalid = 1'b1;
            {in_cpl_tdata, in_cpl_tkeep, in_cpl_tlast, in_cpl_tuser} = cpl_txq[0];
          end else in_cpl_tvalid = 1'b0;
        end
        if (!(in_req_tvalid && !req_fired)) begin
          if (req_txq.size() > 0 && $urandom_range(99) < vld_pct) begin
            in_req_tvalid = 1'b1;
            {in_req_tdata, in_req_tkeep, in_req_tlast, in_req_tuser} = req_txq[0];
          end else in_req_tvalid = 1'b0;
        end
      end
      rr_cpl_tvalid = rr_en;
      rr_cpl_tdata  = DW'(rr_cpl_n);
      rr_cpl_tlast  = (rr_cpl_n % 3 == 2);
      rr_req_tvalid = rr_en;
      rr_req_tdata  = DW'(rr_req_n);
      rr_req_tlast  = (rr_req_n % 2 == 1);
    end
  end

  // Monitor: accepted input beats feed the expected queues, output beats the observed queue.
  initial begin : mon
    obs_t o;
    forever begin
      @(negedge clk);
      cpl_fired = 1'b0;
      req_fired = 1'b0;
      if (rst_n) begin
        if (in_cpl_tvalid && in_cpl_tready && cpl_txq.size() > 0) begin
          exp_cpl.push_back(cpl_txq.pop_front());
          cpl_fired = 1'b1;
          if (cpl_first_acc < 0) cpl_first_acc = cyc;
        end
        if (in_req_tvalid && in_req_tready && req_txq.size() > 0) begin
          exp_req.push_back(req_txq.pop_front());
          req_fired = 1'b1;
        end
        if (in_req_tready) req_rdy_seen = 1'b1;
        if (out_tvalid && out_tready) begin
          o.src = out_src;
          o.cyc = 32'(cyc);
          o.b   = {out_tdata, out_tkeep, out_tlast, out_tuser};
          obs.push_back(o);
        end
        if (rr_cpl_tvalid && rr_cpl_tready) rr_cpl_n = rr_cpl_n + 1;
        if (rr_req_tvalid && rr_req_tready) rr_req_n = rr_req_n + 1;
        if (rr_out_tvalid && rr_out_tready) rr_obs.push_back({rr_out_src, rr_out_tdata[31:0]});
      end
    end
  end

  task automatic gen_pkt(input bit src, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data       = {16{$urandom()}};
      b.data[31:0] = {src, 15'(pkt_seq), 16'(i)};
      b.keep       = {$urandom(), $urandom()};
      b.last       = (i == nb - 1);
      b.user       = UW'($urandom());
      if (src) req_txq.push_back(b);
      else     cpl_txq.push_back(b);
    end
    pkt_seq = pkt_seq + 1;
  endtask

  task automatic clear_all();
    cpl_txq.delete(); req_txq.delete();
    exp_cpl.delete(); exp_req.delete();
    obs.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    clear_all();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int c = 0; c < budget && obs.size() < n; c++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_out_tvalid got=%b want=0", out_tvalid); end
    checks++; if (in_cpl_tready !== 1'b0) begin failures++; $display("FAIL reset_cpl_tready got=%b want=0", in_cpl_tready); end
    checks++; if (in_req_tready !== 1'b0) begin failures++; $display("FAIL reset_req_tready got=%b want=0", in_req_tready); end
    checks++; if (out_src !== 1'b0) begin failures++; $display("FAIL reset_out_src got=%b want=0", out_src); end
    do_reset();
  endtask

  task automatic test_cpl_only();
    obs_t o;
    beat_t e;
    do_reset();
    vld_pct = 100; rdy_pct = 100; req_rdy_seen = 1'b0; cpl_first_acc = -1;
    for (int i = 0; i < 3; i++) gen_pkt(1'b0, 1);
    wait_obs(3, 50);
    checks++;
    if (obs.size() != 3) begin failures++; $display("FAIL cpl_only_count got=%0d want=3", obs.size()); end
    for (int i = 0; i < 3 && obs.size() > 0 && exp_cpl.size() > 0; i++) begin
      o = obs.pop_front();
      e = exp_cpl.pop_front();
      checks++; if (o.src !== 1'b0) begin failures++; $display("FAIL cpl_only_src got=%b want=0", o.src); end
      checks++; if (o.b !== e) begin failures++; $display("FAIL cpl_only_beat got=%h want=%h", o.b, e); end
      checks++;
      if (o.cyc !== 32'(cpl_first_acc + 1 + i)) begin
        failures++; $display("FAIL cpl_only_latency got=%0d want=%0d", o.cyc, cpl_first_acc + 1 + i);
      end
    end
    checks++; if (req_rdy_seen !== 1'b0) begin failures++; $display("FAIL cpl_only_req_tready got=1 want=0"); end
  endtask

  task automatic test_cpl_priority();
    obs_t o;
    beat_t e;
    logic want;
    do_reset();
    vld_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 12; i++) gen_pkt(1'b0, 1);
    for (int i = 0; i < 3; i++) gen_pkt(1'b1, 1);
    wait_obs(15, 100);
    checks++;
    if (obs.size() != 15) begin failures++; $display("FAIL prio_count got=%0d want=15", obs.size()); end
    for (int i = 0; i < 15 && obs.size() > 0; i++) begin
      o = obs.pop_front();
      want = (i % 5 == 4);
      checks++; if (o.src !== want) begin failures++; $display("FAIL prio_src idx=%0d got=%b want=%b", i, o.src, want); end
      if (o.src ? exp_req.size() > 0 : exp_cpl.size() > 0) begin
        e = o.src ? exp_req.pop_front() : exp_cpl.pop_front();
        checks++; if (o.b !== e) begin failures++; $display("FAIL prio_beat got=%h want=%h", o.b, e); end
      end
    end
  endtask

  task automatic test_lock();
    obs_t o;
    beat_t e;
    logic want;
    do_reset();
    vld_pct = 100; rdy_pct = 100;
    gen_pkt(1'b0, 4);
    for (int c = 0; c < 20 && exp_cpl.size() < 2; c++) begin
      @(negedge clk);
      #1;
    end
    gen_pkt(1'b1, 2);
    wait_obs(6, 50);
    checks++;
    if (obs.size() != 6) begin failures++; $display("FAIL lock_count got=%0d want=6", obs.size()); end
    for (int i = 0; i < 6 && obs.size() > 0; i++) begin
      o = obs.pop_front();
      want = (i >= 4);
      checks++; if (o.src !== want) begin failures++; $display("FAIL lock_src idx=%0d got=%b want=%b", i, o.src, want); end
      if (o.src ? exp_req.size() > 0 : exp_cpl.size() > 0) begin
        e = o.src ? exp_req.pop_front() : exp_cpl.pop_front();
        checks++; if (o.b !== e) begin failures++; $display("FAIL lock_beat got=%h want=%h", o.b, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    beat_t e, first;
    do_reset();
    vld_pct = 100; rdy_pct = 0;
    gen_pkt(1'b0, 6);
    first = cpl_txq[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (i >= 2) begin
        checks++; if (in_cpl_tready !== 1'b0) begin failures++; $display("FAIL bp_tready cyc=%0d got=%b want=0", i, in_cpl_tready); end
        checks++; if (out_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid cyc=%0d got=%b want=1", i, out_tvalid); end
        checks++;
        if (out_tdata !== first.data) begin
          failures++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", i, out_tdata[63:0], first.data[63:0]);
        end
      end
    end
    checks++; if (exp_cpl.size() != 2) begin failures++; $display("FAIL bp_buffered got=%0d want=2", exp_cpl.size()); end
    rdy_pct = 100;
    wait_obs(6, 50);
    checks++;
    if (obs.size() != 6) begin failures++; $display("FAIL bp_count got=%0d want=6", obs.size()); end
    while (obs.size() > 0 && exp_cpl.size() > 0) begin
      o = obs.pop_front();
      e = exp_cpl.pop_front();
      checks++; if (o.b !== e) begin failures++; $display("FAIL bp_beat got=%h want=%h", o.b, e); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    beat_t e;
    bit in_pkt, pkt_src, done;
    int budget;
    do_reset();
    vld_pct = 70; rdy_pct = 80;
    in_pkt = 1'b0; pkt_src = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int p = 0; p < (ph == 0 ? 100 : 4900); p++) begin
        gen_pkt(1'b0, $urandom_range(1, 4));
        gen_pkt(1'b1, $urandom_range(1, 4));
      end
      budget = (ph == 0) ? 300 : 70000;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
        @(negedge clk);
        #1;
        while (obs.size() > 0) begin
          o = obs.pop_front();
          checks++;
          if (in_pkt && o.src !== pkt_src) begin
            failures++; $display("FAIL rand_interleave got_src=%b want_src=%b", o.src, pkt_src);
          end
          in_pkt = !o.b.last;
          pkt_src = o.src;
          checks++;
          if (o.src ? exp_req.size() == 0 : exp_cpl.size() == 0) begin
            failures++; $display("FAIL rand_unexpected src=%b got=%h want=none", o.src, o.b.data[31:0]);
          end else begin
            e = o.src ? exp_req.pop_front() : exp_cpl.pop_front();
            if (o.b !== e) begin failures++; $display("FAIL rand_beat src=%b got=%h want=%h", o.src, o.b, e); end
          end
        end
        if (ph == 1)
          done = (cpl_txq.size() == 0 && req_txq.size() == 0 && exp_cpl.size() == 0 && exp_req.size() == 0);
      end
      if (ph == 0) begin
        for (int c = 0; c < 500; c++) begin
          @(posedge clk);
          #2;
          if (in_cpl_tvalid && in_cpl_tready && !in_cpl_tlast) break;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_out_tvalid got=%b want=0", out_tvalid); end
        checks++; if (in_cpl_tready !== 1'b0) begin failures++; $display("FAIL midrst_cpl_tready got=%b want=0", in_cpl_tready); end
        checks++; if (in_req_tready !== 1'b0) begin failures++; $display("FAIL midrst_req_tready got=%b want=0", in_req_tready); end
        checks++; if (out_src !== 1'b0) begin failures++; $display("FAIL midrst_out_src got=%b want=0", out_src); end
        clear_all();
        repeat (2) @(negedge clk);
        clear_all();
        in_pkt = 1'b0;
        rst_n = 1'b1;
      end else begin
        checks++;
        if (!done) begin
          failures++;
          $display("FAIL rand_timeout got=%0d/%0d pending want=0/0", exp_cpl.size(), exp_req.size());
        end
      end
    end
    rdy_pct = 100;
  endtask

  task automatic test_rr();
    logic [32:0] r;
    logic want;
    int unsigned nc, nr;
    do_reset();
    rr_obs.delete();
    rr_en = 1'b1;
    for (int c = 0; c < 100 && rr_obs.size() < 20; c++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (rr_obs.size() < 20) begin failures++; $display("FAIL rr_count got=%0d want=20", rr_obs.size()); end
    nc = 0; nr = 0;
    for (int i = 0; i < 20 && rr_obs.size() > 0; i++) begin
      r = rr_obs.pop_front();
      want = ((i % 5) >= 3);
      checks++; if (r[32] !== want) begin failures++; $display("FAIL rr_src idx=%0d got=%b want=%b", i, r[32], want); end
      checks++;
      if (r[31:0] !== (want ? nr : nc)) begin
        failures++; $display("FAIL rr_data idx=%0d got=%0d want=%0d", i, r[31:0], want ? nr : nc);
      end
      if (want) nr++;
      else      nc++;
    end
    rr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_cpl_only();
    test_cpl_priority();
    test_lock();
    test_backpressure();
    test_random();
    test_rr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_ss_axis_tx_dual_merge.md
Name: pcie_ss_axis_tx_dual_merge

Overview:
- TX-side counterpart of the RX dual-stream fork.
- Merges a completion stream (CplD responses to host MMIO reads) and a request stream (DMA MemRd/MemWr, messages) into one PCIe SS TX AXI-S stream toward the subsystem.
- Arbitration is packet-atomic at tlast boundaries; the output is registered through a 2-entry skid buffer.

Parameters:
- DATA_WIDTH, 512, tdata width in bits.
- NUM_OF_SEG, DATA_WIDTH/256, segments per beat. Carried only in tuser; not interpreted.
- USER_W, NUM_OF_SEG*$bits(ofs_fim_pcie_ss_shims_pkg::t_tuser_seg), tuser width. Passed through opaquely.
- CPL_PRIORITY, 1. 1 = completions win ties, subject to a burst limit. 0 = strict round-robin.
- MAX_CPL_BURST, 4. Consecutive CPL packets granted while REQ waits before REQ is forced. Range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_cpl_tvalid / in_cpl_tready  in / out  1 / 1  completion stream handshake
- in_cpl_tdata / in_cpl_tkeep  in  DATA_WIDTH / DATA_WIDTH/8  completion data, byte enables
- in_cpl_tlast / in_cpl_tuser  in  1 / USER_W  completion end-of-packet, sideband
- in_req_tvalid / in_req_tready / in_req_tdata / in_req_tkeep / in_req_tlast / in_req_tuser  same widths  request stream
- out_tvalid / out_tready  out / in  1 / 1  merged stream handshake
- out_tdata / out_tkeep / out_tlast / out_tuser  out  same widths  merged stream payload
- out_src  out  1  debug: 0 = current out beat from CPL, 1 = from REQ

Behaviour:
- Reset (async assert, sync release): out_tvalid=0, skid empty, in_*_tready=0, FSM=IDLE, burst counter=0, rr pointer=CPL, out_src=0. Payload outputs don't-care.
- Input contract: tlast=1 means no packet continues into the next beat, whatever last_segment says. tlast is the only arbitration point.
- FSM states:
  - IDLE: pick a source per the rules below. If the picked beat is accepted with tlast=0, go to LOCK_CPL or LOCK_REQ. With tlast=1, stay in IDLE.
  - LOCK_CPL / LOCK_REQ: only the locked source gets tready. Return to IDLE on acceptance of its tlast beat.
  - The unselected source always sees tready=0.
- Arbitration in IDLE, CPL_PRIORITY=1:
  - Only one valid: pick it.
  - Both valid: pick REQ if burst_cnt==MAX_CPL_BURST, else CPL.
  - burst_cnt increments on each CPL packet start (first beat accepted) while in_req_tvalid=1, saturating at MAX_CPL_BURST.
  - burst_cnt clears on any REQ packet start.
- Arbitration in IDLE, CPL_PRIORITY=0: both valid → pick the rr pointer source. The pointer flips to the other source on each packet start.
- Selected in_*_tready = skid not full. Beats enter the skid buffer on valid&ready.
- Latency: first beat appears on out_* the cycle after acceptance. Full throughput (1 beat/clk) under continuous out_tready=1.
- Skid buffer: 2 entries; out_* driven from the head register.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full: all input treadys low.
  - Empty: out_tvalid=0.
- out_* stable while out_tvalid=1 and out_tready=0 (AXI-S rule).
- Beat order within each source is preserved. Packets from the two sources never interleave at beat granularity.
- Reset mid-packet: in-flight beats are dropped and the FSM returns to IDLE. Upstream must also be reset.

Decomposition:
- ofs_fim_pcie_ss_shims_pkg gains t_tx_merge_state (IDLE, LOCK_CPL, LOCK_REQ) and a source-id enum (SRC_CPL=0, SRC_REQ=1).
- One sub-module: pcie_ss_axis_skid2. Generic 2-entry registered skid buffer over {tdata, tkeep, tlast, tuser, src}, same clk/rst_n.

Test Plan:
- Only CPL valid, 3 single-beat packets, out_tready=1 → 3 output beats on consecutive cycles starting 1 clk after the first accept; out_src=0; in_req_tready stays 0.
- Both streams continuously valid, single-beat packets, CPL_PRIORITY=1, MAX_CPL_BURST=4 → output source pattern C,C,C,C,R repeating.
- CPL_PRIORITY=0, both valid, CPL packet = 3 beats, REQ packet = 2 beats → output C,C,C,R,R,C,C,C,…; no interleave inside a packet.
- REQ asserts valid mid-way through a 4-beat CPL packet → REQ beats start only after the CPL tlast beat is emitted.
- out_tready=0 for 5 cycles with CPL streaming → exactly 2 beats buffered; in_cpl_tready low from the cycle after the skid fills; output stable; no loss when released.
- Random valid/tready on all ports, 10000 packets, order checked per source against reference queues → zero mismatches. Includes an rst_n pulse mid-packet: all outputs at reset values within the same cycle.
